// File: rtl/debounce_pulse_if.sv
// Conditioned-input bundle: the raw bouncy input and everything the debouncer
// reports back (clean level, edge pulses, busy flag, accepted-edge count).
interface debounce_pulse_if;
  logic       raw_in;
  logic       level;
  logic       rise;
  logic       fall;
  logic       busy;
  logic [7:0] edge_count;

  modport master (
    output raw_in,
    input  level, rise, fall, busy, edge_count
  );

  modport slave (
    input  raw_in,
    output level, rise, fall, busy, edge_count
  );
endinterface

// File: rtl/debounce_pulse.sv
// Two-flop synchroniser plus a four-state qualifier: a new input value must be
// seen for STABLE_CYCLES consecutive samples before level, rise/fall and edge_count move.
module debounce_pulse #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 16
) (
  input logic              clk,
  input logic              reset,
  debounce_pulse_if.slave  dp
);

  localparam logic [1:0] LOW    = 2'd0;
  localparam logic [1:0] WAIT_H = 2'd1;
  localparam logic [1:0] HIGH   = 2'd2;
  localparam logic [1:0] WAIT_L = 2'd3;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             sync1;
  logic             s;
  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             qual_rise;
  logic             qual_fall;
  logic             level_q;
  logic             rise_q;
  logic             fall_q;
  logic             busy_q;
  logic [7:0]       edge_count_q;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    qual_rise = 1'b0;
    qual_fall = 1'b0;
    case (state)
      LOW: begin
        if (s) begin
          state_nxt = WAIT_H;
          cnt_nxt   = '0;
        end
      end
      WAIT_H: begin
        // Bounce check takes priority over qualification on the final sample.
        if (!s) begin
          state_nxt = LOW;
          cnt_nxt   = '0;
        end else if (cnt == LAST) begin
          state_nxt = HIGH;
          qual_rise = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      HIGH: begin
        if (!s) begin
          state_nxt = WAIT_L;
          cnt_nxt   = '0;
        end
      end
      WAIT_L: begin
        if (s) begin
          state_nxt = HIGH;
          cnt_nxt   = '0;
        end else if (cnt == LAST) begin
          state_nxt = LOW;
          qual_fall = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = LOW;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1        <= 1'b0;
      s            <= 1'b0;
      state        <= LOW;
      cnt          <= '0;
      level_q      <= 1'b0;
      rise_q       <= 1'b0;
      fall_q       <= 1'b0;
      busy_q       <= 1'b0;
      edge_count_q <= '0;
    end else begin
      sync1   <= dp.raw_in;
      s       <= sync1;
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      rise_q  <= qual_rise;
      fall_q  <= qual_fall;
      busy_q  <= (state_nxt == WAIT_H) || (state_nxt == WAIT_L);
      if (qual_rise) level_q <= 1'b1;
      if (qual_fall) level_q <= 1'b0;
      if (qual_rise || qual_fall) edge_count_q <= edge_count_q + 8'd1;
    end
  end

  assign dp.level      = level_q;
  assign dp.rise       = rise_q;
  assign dp.fall       = fall_q;
  assign dp.busy       = busy_q;
  assign dp.edge_count = edge_count_q;

endmodule

// File: doc/debounce_pulse.md
Name: debounce_pulse

Overview:
- Front-end conditioning stage that sits directly upstream of the enable flip-flop.
- Takes a raw asynchronous input (push-button or switch), synchronises it into the clk domain, and filters bounce.
- Produces a clean level, which drives the flip-flop's d input.
- Produces single-cycle rise and fall pulses, which drive its en input.
- Also keeps a wrapping count of accepted edges for lab observation.

Parameters:
- STABLE_CYCLES, 4, consecutive synchronised samples at a new value required before accepting it. Legal range 1..65535.
- CNT_W, 16, width of the internal stability counter. Must hold STABLE_CYCLES-1.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- raw_in  input  1  unsynchronised bouncy input
- level  output  1  debounced level, registered
- rise  output  1  one-cycle pulse when level goes 0->1
- fall  output  1  one-cycle pulse when level goes 1->0
- busy  output  1  high while a candidate change is being qualified (WAIT states)
- edge_count  output  8  number of accepted edges (rise or fall), wraps at 255->0

Behaviour:
- Reset: clk and reset as already decided (reset asynchronous, active-high; clock clk). While reset=1, every flop is 0: sync chain, state, counter, level, rise, fall, busy and edge_count. State is LOW.
- Synchroniser: two flops, sync1 <= raw_in, s <= sync1. The FSM sees only s.
- State LOW (level=0):
  - if s=1, go to WAIT_H and clear the counter.
- State WAIT_H (busy=1):
  - if s=0, return to LOW. This is a bounce: no pulse, counter cleared.
  - else if cnt=STABLE_CYCLES-1, go to HIGH. On the same edge: level<=1, rise<=1, edge_count<=edge_count+1.
  - else cnt<=cnt+1.
- State HIGH (level=1):
  - if s=0, go to WAIT_L and clear the counter.
- State WAIT_L: mirror of WAIT_H. Bounce (s=1) returns to HIGH. Qualification sets level<=0, fall<=1 and increments edge_count.
- Pulses: rise and fall are high for exactly one cycle and are never high together. They are deasserted on the following edge regardless of input.
- busy: registered, equal to 1 exactly when the state is WAIT_H or WAIT_L.
- Latency: take the first edge that samples raw_in=1 as edge 1, with raw_in steady. Then s=1 after edge 2, WAIT_H is entered at edge 3, and level/rise assert at edge 3+STABLE_CYCLES. With STABLE_CYCLES=4 that is edge 7. Falling transitions are symmetric.
- STABLE_CYCLES=1: the WAIT state lasts one cycle. Latency is edge 4.
- Any s glitch shorter than STABLE_CYCLES samples inside WAIT aborts qualification. Level is unchanged and no pulse is produced. Re-qualification restarts from cnt=0 on the next opposite sample.
- edge_count is 8-bit unsigned and wraps modulo 256 with no flag.
- Reset mid-qualification: all outputs return to 0 immediately (asynchronously) and no pulse is emitted. After release, if raw_in is still 1, the block re-qualifies from LOW and produces a rise. This is intended.
- raw_in toggling every cycle never qualifies, for any STABLE_CYCLES>=2.

Test Plan:
- Reset with raw_in=0, release, hold 20 cycles -> level=0, rise=fall=busy=0, edge_count=0 throughout.
- STABLE_CYCLES=4, raw_in 0->1 clean before edge 1 -> busy=1 from edge 3 to edge 6; level=1 and rise=1 at edge 7; rise=0 at edge 8; edge_count=1.
- From level=1, raw_in pulses low for 2 cycles then returns high -> busy asserts then clears, level stays 1, fall never asserts, edge_count unchanged.
- raw_in toggled every cycle for 50 cycles from level=0 -> level=0, no rise/fall pulses, edge_count=0.
- Assert reset at the cycle busy first goes high, with raw_in held 1 -> outputs 0 during reset; after release, rise occurs exactly 3+STABLE_CYCLES edges later; edge_count=1.
- 256 clean alternating qualified transitions -> edge_count returns to 0; the rise and fall pulse counts are 128 each.
